reorder_buffer: RTL and testbench

REORDER_BUFFER -- requirements
Module: reorder_buffer

---
 rtl/reorder_buffer.sv | 146 ++++++++++++++
 tb/tb_reorder_buffer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - dual-issue, dual-commit in-order reorder buffer
package core_pkg;
    parameter int XLEN = 32;
endpackage

module reorder_buffer #(
    parameter int XLEN        = core_pkg::XLEN,
    parameter int ROB_ENTRIES = 16,
    parameter int IDX_W       = $clog2(ROB_ENTRIES)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [1:0]                  alloc_valid,
    input  logic [1:0]                  alloc_has_rd,
    input  logic [1:0][4:0]             alloc_rd,
    output logic                        alloc_ready,
    output logic [1:0][IDX_W-1:0]       alloc_idx,
    input  logic [1:0]                  wb_valid,
    input  logic [1:0][IDX_W-1:0]       wb_idx,
    input  logic [1:0][XLEN-1:0]        wb_data,
    input  logic [1:0]                  wb_exc,
    output logic [1:0]                  commit_wen,
    output logic [1:0][4:0]             commit_waddr,
    output logic [1:0][XLEN-1:0]        commit_wdata,
    output logic                        flush,
    output logic [IDX_W:0]              count
);

    logic [ROB_ENTRIES-1:0] busy;
    logic [ROB_ENTRIES-1:0] done;
    logic [ROB_ENTRIES-1:0] exc;
    logic [ROB_ENTRIES-1:0] has_rd;
    logic [4:0]             rd   [ROB_ENTRIES];
    logic [XLEN-1:0]        data [ROB_ENTRIES];

    logic [IDX_W-1:0] head;
    logic [IDX_W-1:0] tail;
    logic [IDX_W-1:0] head1;
    logic [IDX_W-1:0] tail1;

    logic       acc0;
    logic       acc1;
    logic       ret0;
    logic       ret1;
    logic       same_rd;
    logic       exc_head;
    logic [1:0] n_alloc;
    logic [1:0] n_ret;

    assign head1 = head + IDX_W'(1);
    assign tail1 = tail + IDX_W'(1);

    // Readiness deliberately ignores entries retiring this cycle.
    assign alloc_ready  = (count <= (IDX_W+1)'(ROB_ENTRIES - 2));
    assign alloc_idx[0] = tail;
    assign alloc_idx[1] = tail1;

    assign acc0 = alloc_ready & alloc_valid[0];
    assign acc1 = acc0 & alloc_valid[1];

    // A younger write to the same register is deferred so the register file
    // never sees two writes to one address in a single cycle.
    assign same_rd  = has_rd[head] & has_rd[head1] & (rd[head] == rd[head1]);
    assign ret0     = busy[head] & done[head] & ~exc[head];
    assign ret1     = ret0 & busy[head1] & done[head1] & ~exc[head1] & ~same_rd;
    assign exc_head = busy[head] & done[head] & exc[head];

    assign n_alloc = 2'(acc0) + 2'(acc1);
    assign n_ret   = 2'(ret0) + 2'(ret1);

    always_ff @(posedge clk) begin
        if (reset || exc_head) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            busy  <= '0;
            done  <= '0;
            exc   <= '0;
        end else begin
            head  <= head + IDX_W'(n_ret);
            tail  <= tail + IDX_W'(n_alloc);
            count <= count + (IDX_W+1)'(n_alloc) - (IDX_W+1)'(n_ret);
            for (int i = 0; i < ROB_ENTRIES; i++) begin
                if (wb_valid[0] && wb_idx[0] == IDX_W'(i) && busy[i]) begin
                    done[i] <= 1'b1;
                    exc[i]  <= wb_exc[0];
                end
                if (wb_valid[1] && wb_idx[1] == IDX_W'(i) && busy[i]) begin
                    done[i] <= 1'b1;
                    exc[i]  <= wb_exc[1];
                end
                if ((ret0 && head == IDX_W'(i)) || (ret1 && head1 == IDX_W'(i))) begin
                    busy[i] <= 1'b0;
                    done[i] <= 1'b0;
                end
                if ((acc0 && tail == IDX_W'(i)) || (acc1 && tail1 == IDX_W'(i))) begin
                    busy[i] <= 1'b1;
                    done[i] <= 1'b0;
                    exc[i]  <= 1'b0;
                end
            end
        end
    end

    // Payload storage is qualified by the control bits, so it needs no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < ROB_ENTRIES; i++) begin
            if (wb_valid[0] && wb_idx[0] == IDX_W'(i) && busy[i]) begin
                data[i] <= wb_data[0];
            end
            if (wb_valid[1] && wb_idx[1] == IDX_W'(i) && busy[i]) begin
                data[i] <= wb_data[1];
            end
            if (acc0 && tail == IDX_W'(i)) begin
                has_rd[i] <= alloc_has_rd[0];
                rd[i]     <= alloc_rd[0];
            end
            if (acc1 && tail1 == IDX_W'(i)) begin
                has_rd[i] <= alloc_has_rd[1];
                rd[i]     <= alloc_rd[1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            commit_wen   <= '0;
            commit_waddr <= '0;
            commit_wdata <= '0;
            flush        <= 1'b0;
        end else begin
            flush         <= exc_head;
            commit_wen[0] <= ret0 && has_rd[head] && (rd[head] != 5'd0);
            commit_wen[1] <= ret1 && has_rd[head1] && (rd[head1] != 5'd0);
            if (ret0) begin
                commit_waddr[0] <= rd[head];
                commit_wdata[0] <= data[head];
            end
            if (ret1) begin
                commit_waddr[1] <= rd[head1];
                commit_wdata[1] <= data[head1];
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// tb/tb_reorder_buffer.sv - scoreboard bench for reorder_buffer
module tb_reorder_buffer;

    localparam int XLEN = 32;
    localparam int IW   = 4;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [1:0]            alloc_valid;
    logic [1:0]            alloc_has_rd;
    logic [1:0][4:0]       alloc_rd;
    logic                  alloc_ready;
    logic [1:0][IW-1:0]    alloc_idx;
    logic [1:0]            wb_valid;
    logic [1:0][IW-1:0]    wb_idx;
    logic [1:0][XLEN-1:0]  wb_data;
    logic [1:0]            wb_exc;
    logic [1:0]            commit_wen;
    logic [1:0][4:0]       commit_waddr;
    logic [1:0][XLEN-1:0]  commit_wdata;
    logic                  flush;
    logic [IW:0]           count;

    reorder_buffer dut (
        .clk          (clk),
        .reset        (reset),
        .alloc_valid  (alloc_valid),
        .alloc_has_rd (alloc_has_rd),
        .alloc_rd     (alloc_rd),
        .alloc_ready  (alloc_ready),
        .alloc_idx    (alloc_idx),
        .wb_valid     (wb_valid),
        .wb_idx       (wb_idx),
        .wb_data      (wb_data),
        .wb_exc       (wb_exc),
        .commit_wen   (commit_wen),
        .commit_waddr (commit_waddr),
        .commit_wdata (commit_wdata),
        .flush        (flush),
        .count        (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_flush;
        bit          port;
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t expq[$];
    int   vectors     = 0;
    int   miscompares = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void push(input bit f, input bit p, input logic [4:0] a, input logic [31:0] d);
        exp_t e;
        e.is_flush = f;
        e.port     = p;
        e.addr     = a;
        e.data     = d;
        expq.push_back(e);
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (flush) begin
            if (expq.size() == 0) begin
                chk("flush_unexpected", 64'd1, 64'd0);
            end else begin
                e = expq.pop_front();
                chk("flush_expected", 64'd1, 64'(e.is_flush));
            end
        end
        for (int p = 0; p < 2; p++) begin
            if (commit_wen[p]) begin
                if (expq.size() == 0) begin
                    chk("commit_unexpected", 64'(commit_waddr[p]), 64'h3f);
                end else begin
                    e = expq.pop_front();
                    chk("commit_port", 64'(p), {62'd0, e.is_flush, e.port});
                    chk("commit_waddr", 64'(commit_waddr[p]), 64'(e.addr));
                    chk("commit_wdata", 64'(commit_wdata[p]), 64'(e.data));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic alloc2(input logic [1:0] v, input logic [4:0] r0, input logic [4:0] r1);
        alloc_valid  = v;
        alloc_has_rd = 2'b11;
        alloc_rd[0]  = r0;
        alloc_rd[1]  = r1;
        tick();
        alloc_valid  = 2'b00;
    endtask

    task automatic wb(input logic [1:0] v,
                      input logic [3:0] i0, input logic [31:0] d0, input logic e0,
                      input logic [3:0] i1, input logic [31:0] d1, input logic e1);
        wb_valid   = v;
        wb_idx[0]  = i0;
        wb_data[0] = d0;
        wb_exc[0]  = e0;
        wb_idx[1]  = i1;
        wb_data[1] = d1;
        wb_exc[1]  = e1;
        tick();
        wb_valid   = 2'b00;
    endtask

    initial begin
        reset        = 1'b1;
        alloc_valid  = '0;
        alloc_has_rd = '0;
        alloc_rd     = '0;
        wb_valid     = '0;
        wb_idx       = '0;
        wb_data      = '0;
        wb_exc       = '0;
        repeat (2) tick();
        reset = 1'b0;
        chk("reset_count", 64'(count), 64'd0);
        chk("reset_ready", 64'(alloc_ready), 64'd1);
        chk("reset_alloc_idx", 64'(alloc_idx), 64'h10);
        chk("reset_wen", 64'(commit_wen), 64'd0);
        chk("reset_flush", 64'(flush), 64'd0);

        // Pair retire, distinct destinations
        alloc2(2'b11, 5'd3, 5'd4);
        push(0, 0, 5'd3, 32'hA);
        push(0, 1, 5'd4, 32'hB);
        wb(2'b11, 4'd0, 32'hA, 1'b0, 4'd1, 32'hB, 1'b0);
        chk("pair_not_yet_retired", 64'(count), 64'd2);
        tick();
        chk("pair_count_after", 64'(count), 64'd0);

        // Same destination: younger deferred one cycle
        alloc2(2'b11, 5'd5, 5'd5);
        push(0, 0, 5'd5, 32'h11);
        push(0, 0, 5'd5, 32'h22);
        wb(2'b11, 4'd2, 32'h11, 1'b0, 4'd3, 32'h22, 1'b0);
        tick();
        chk("same_rd_one_retired", 64'(count), 64'd1);
        tick();
        chk("same_rd_count_after", 64'(count), 64'd0);

        // rd 0 never writes
        alloc2(2'b11, 5'd0, 5'd7);
        push(0, 1, 5'd7, 32'h44);
        wb(2'b11, 4'd4, 32'h33, 1'b0, 4'd5, 32'h44, 1'b0);
        tick();
        chk("rd0_count_after", 64'(count), 64'd0);

        // Writeback to a free entry is ignored; same-index writeback port1 wins
        wb(2'b01, 4'd6, 32'h99, 1'b0, 4'd0, 32'h0, 1'b0);
        alloc2(2'b11, 5'd8, 5'd9);
        tick();
        tick();
        chk("stale_wb_ignored", 64'(count), 64'd2);
        push(0, 0, 5'd8, 32'h66);
        push(0, 0, 5'd9, 32'h77);
        wb(2'b11, 4'd6, 32'h55, 1'b0, 4'd6, 32'h66, 1'b0);
        chk("wb_takes_a_cycle", 64'(count), 64'd2);
        wb(2'b01, 4'd7, 32'h77, 1'b0, 4'd0, 32'h0, 1'b0);
        chk("single_retire", 64'(count), 64'd1);
        tick();
        chk("wb_conflict_drained", 64'(count), 64'd0);

        // Fill to 16 entries, starting at entry 8
        for (int k = 0; k < 8; k++) begin
            alloc2(2'b11, 5'(1 + 2 * k), 5'(2 + 2 * k));
            if (k == 6) begin
                chk("fill_count14", 64'(count), 64'd14);
                chk("fill_ready14", 64'(alloc_ready), 64'd1);
            end
        end
        for (int j = 0; j < 16; j++) push(0, 0, 5'(1 + j), 32'(32'h100 + j));
        chk("full_count", 64'(count), 64'd16);
        chk("full_ready", 64'(alloc_ready), 64'd0);
        alloc2(2'b11, 5'd30, 5'd31);
        chk("full_alloc_blocked", 64'(count), 64'd16);
        wb(2'b01, 4'd8, 32'h100, 1'b0, 4'd0, 32'h0, 1'b0);
        tick();
        chk("count15_after_retire", 64'(count), 64'd15);
        chk("count15_ready", 64'(alloc_ready), 64'd0);
        alloc2(2'b11, 5'd30, 5'd31);
        chk("count15_alloc_blocked", 64'(count), 64'd15);
        for (int j = 1; j < 16; j++) begin
            wb(2'b01, 4'((8 + j) % 16), 32'(32'h100 + j), 1'b0, 4'd0, 32'h0, 1'b0);
        end
        tick();
        tick();
        chk("drain_count", 64'(count), 64'd0);

        // Tail wrap past entry 15
        alloc2(2'b11, 5'd20, 5'd21);
        alloc2(2'b11, 5'd22, 5'd23);
        alloc2(2'b11, 5'd24, 5'd25);
        alloc2(2'b01, 5'd26, 5'd0);
        chk("wrap_alloc_idx", 64'(alloc_idx), 64'h0f);
        chk("wrap_count7", 64'(count), 64'd7);
        alloc2(2'b11, 5'd27, 5'd28);
        chk("wrap_count9", 64'(count), 64'd9);
        for (int n = 0; n < 9; n++) push(0, 1'(n % 2), 5'(20 + n), 32'(32'h200 + n));
        wb(2'b11, 4'd0,  32'h208, 1'b0, 4'd15, 32'h207, 1'b0);
        wb(2'b11, 4'd14, 32'h206, 1'b0, 4'd13, 32'h205, 1'b0);
        wb(2'b11, 4'd12, 32'h204, 1'b0, 4'd11, 32'h203, 1'b0);
        wb(2'b11, 4'd10, 32'h202, 1'b0, 4'd9,  32'h201, 1'b0);
        wb(2'b01, 4'd8,  32'h200, 1'b0, 4'd0,  32'h0,   1'b0);
        chk("wrap_no_early_commit", 64'(count), 64'd9);
        repeat (6) tick();
        chk("wrap_drained", 64'(count), 64'd0);

        // Reset with six entries in flight, two already done
        alloc2(2'b11, 5'd1, 5'd2);
        alloc2(2'b11, 5'd3, 5'd4);
        alloc2(2'b11, 5'd5, 5'd6);
        chk("six_busy", 64'(count), 64'd6);
        wb(2'b11, 4'd1, 32'h1, 1'b0, 4'd2, 32'h2, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midreset_count", 64'(count), 64'd0);
        chk("midreset_ready", 64'(alloc_ready), 64'd1);
        chk("midreset_alloc_idx", 64'(alloc_idx), 64'h10);
        chk("midreset_wen", 64'(commit_wen), 64'd0);
        repeat (3) tick();

        // Exception at head; same-edge alloc and writeback discarded
        alloc2(2'b11, 5'd3, 5'd4);
        push(1, 0, 5'd0, 32'h0);
        wb(2'b11, 4'd0, 32'hE, 1'b1, 4'd1, 32'hF, 1'b0);
        alloc_valid  = 2'b11;
        alloc_rd[0]  = 5'd10;
        alloc_rd[1]  = 5'd11;
        wb_valid     = 2'b01;
        wb_idx[0]    = 4'd2;
        tick();
        alloc_valid  = 2'b00;
        wb_valid     = 2'b00;
        chk("exc_flush_high", 64'(flush), 64'd1);
        chk("exc_count", 64'(count), 64'd0);
        chk("exc_alloc_idx", 64'(alloc_idx), 64'h10);
        chk("exc_no_wen", 64'(commit_wen), 64'd0);
        tick();
        chk("exc_flush_low", 64'(flush), 64'd0);
        chk("exc_count_stays", 64'(count), 64'd0);
        repeat (3) tick();

        chk("scoreboard_empty", 64'(expq.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
